// File: rtl/bit_stream_pkg.sv
// Shared types and constants for the enable-qualified serial transmitter.
package bit_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_GAP_CYC = 0;
    localparam int DEF_CNT_W   = 16;

    // Width needed to index n distinct values (0..n-1), never below one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bit_stream_tx_if.sv
// Word handshake in, serial stream out; master drives words, slave is the transmitter.
interface bit_stream_tx_if
    import bit_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              o_en;
    logic              o_d;
    logic              o_last;
    logic              o_busy;
    logic [CNT_W-1:0]  o_word_cnt;

    modport master (
        output s_valid, s_data,
        input  s_ready, o_en, o_d, o_last, o_busy, o_word_cnt
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, o_en, o_d, o_last, o_busy, o_word_cnt
    );
endinterface

// File: rtl/bit_stream_shreg.sv
// Loadable shift register: first_o is the first bit of din, bit_o the next bit still to send.
module bit_stream_shreg
    import bit_stream_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LSB_FIRST = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              first_o,
    output logic              bit_o
);
    // Only the DATA_W-1 bits after the first are stored; the first goes straight to the output flop.
    logic [DATA_W-2:0] data_q, data_d;
    logic [DATA_W-2:0] load_val, shift_val;

    generate
        if (LSB_FIRST != 0) begin : g_lsb
            assign first_o   = din[0];
            assign load_val  = din[DATA_W-1:1];
            assign bit_o     = data_q[0];
            assign shift_val = data_q >> 1;
        end else begin : g_msb
            assign first_o   = din[DATA_W-1];
            assign load_val  = din[DATA_W-2:0];
            assign bit_o     = data_q[DATA_W-2];
            assign shift_val = data_q << 1;
        end
    endgenerate

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = load_val;
        end else if (shift) begin
            data_d = shift_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end
endmodule

// File: rtl/bit_stream_tx.sv
// Word-to-serial transmitter: one-word hold buffer, shift FSM, optional inter-word gap, word counter.
module bit_stream_tx
    import bit_stream_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int LSB_FIRST = 0,
    parameter int GAP_CYC   = DEF_GAP_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    bit_stream_tx_if.slave  bus
);
    localparam int IDX_W = idx_w(DATA_W);
    localparam int GAP_W = idx_w(GAP_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(DATA_W - 2);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic              en_q, en_d;
    logic              d_q, d_d;
    logic              last_q, last_d;

    logic load, shift, start, first_bit, next_bit;

    bit_stream_shreg #(
        .DATA_W    (DATA_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_shreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .shift   (shift),
        .din     (hold_q),
        .first_o (first_bit),
        .bit_o   (next_bit)
    );

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        bit_idx_d    = bit_idx_q;
        gap_cnt_d    = gap_cnt_q;
        word_cnt_d   = word_cnt_q;
        en_d         = 1'b0;
        d_d          = 1'b0;
        last_d       = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        start        = 1'b0;

        // s_ready is just !hold_valid_q, so an accept never coincides with a load.
        if (bus.s_valid && !hold_valid_q) begin
            hold_d       = bus.s_data;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                start = hold_valid_q;
            end
            SHIFT: begin
                if (bit_idx_q == LAST_IDX) begin
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    if (GAP_CYC > 0) begin
                        state_d   = GAP;
                        gap_cnt_d = GAP_W'(GAP_CYC);
                    end else if (hold_valid_q) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    shift     = 1'b1;
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                    en_d      = 1'b1;
                    d_d       = next_bit;
                    last_d    = (bit_idx_q == PENULT_IDX);
                end
            end
            GAP: begin
                if (gap_cnt_q <= GAP_W'(1)) begin
                    gap_cnt_d = '0;
                    if (hold_valid_q) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Loading drives the first bit on this same edge, so the word starts without a dead cycle.
        if (start) begin
            load         = 1'b1;
            hold_valid_d = 1'b0;
            state_d      = SHIFT;
            bit_idx_d    = '0;
            en_d         = 1'b1;
            d_d          = first_bit;
            last_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            bit_idx_q    <= '0;
            gap_cnt_q    <= '0;
            word_cnt_q   <= '0;
            en_q         <= 1'b0;
            d_q          <= 1'b0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            bit_idx_q    <= bit_idx_d;
            gap_cnt_q    <= gap_cnt_d;
            word_cnt_q   <= word_cnt_d;
            en_q         <= en_d;
            d_q          <= d_d;
            last_q       <= last_d;
        end
    end

    assign bus.s_ready    = !hold_valid_q;
    assign bus.o_en       = en_q;
    assign bus.o_d        = d_q;
    assign bus.o_last     = last_q;
    assign bus.o_busy     = (state_q != IDLE) || hold_valid_q;
    assign bus.o_word_cnt = word_cnt_q;
endmodule

// File: tb/tb_bit_stream_tx.sv
// Bench for bit_stream_tx: four configurations checked against a word-level serial stream model.
module tb_bit_stream_tx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0] valid;
    logic [7:0] data [4];
    wire  [3:0] ready, en, d, last, busy;
    wire  [15:0] cnt [4];

    int checks = 0;
    int errors = 0;
    int model_cnt [4];
    int cnt_mask [4] = '{32'hFFFF, 32'hFFFF, 32'hFFFF, 3};
    logic [7:0] wq [$];

    bit_stream_tx_if #(.DATA_W(8), .CNT_W(16)) bus0 ();
    bit_stream_tx_if #(.DATA_W(8), .CNT_W(16)) bus1 ();
    bit_stream_tx_if #(.DATA_W(8), .CNT_W(16)) bus2 ();
    bit_stream_tx_if #(.DATA_W(8), .CNT_W(2))  bus3 ();

    bit_stream_tx #(.DATA_W(8), .LSB_FIRST(0), .GAP_CYC(0), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    bit_stream_tx #(.DATA_W(8), .LSB_FIRST(1), .GAP_CYC(0), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    bit_stream_tx #(.DATA_W(8), .LSB_FIRST(0), .GAP_CYC(3), .CNT_W(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    bit_stream_tx #(.DATA_W(8), .LSB_FIRST(0), .GAP_CYC(0), .CNT_W(2))  dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    assign bus0.s_valid = valid[0];  assign bus0.s_data = data[0];
    assign bus1.s_valid = valid[1];  assign bus1.s_data = data[1];
    assign bus2.s_valid = valid[2];  assign bus2.s_data = data[2];
    assign bus3.s_valid = valid[3];  assign bus3.s_data = data[3];

    assign ready[0] = bus0.s_ready; assign en[0] = bus0.o_en; assign d[0] = bus0.o_d;
    assign last[0]  = bus0.o_last;  assign busy[0] = bus0.o_busy; assign cnt[0] = bus0.o_word_cnt;
    assign ready[1] = bus1.s_ready; assign en[1] = bus1.o_en; assign d[1] = bus1.o_d;
    assign last[1]  = bus1.o_last;  assign busy[1] = bus1.o_busy; assign cnt[1] = bus1.o_word_cnt;
    assign ready[2] = bus2.s_ready; assign en[2] = bus2.o_en; assign d[2] = bus2.o_d;
    assign last[2]  = bus2.o_last;  assign busy[2] = bus2.o_busy; assign cnt[2] = bus2.o_word_cnt;
    assign ready[3] = bus3.s_ready; assign en[3] = bus3.o_en; assign d[3] = bus3.o_d;
    assign last[3]  = bus3.o_last;  assign busy[3] = bus3.o_busy; assign cnt[3] = {14'd0, bus3.o_word_cnt};

    // Feeds words into instance k, records the serial stream, and compares it with the word-level model.
    task automatic run_words(input int k, input logic [7:0] words[$], input bit lsb,
                             input int gap, input bit contig, input string name);
        int n = words.size();
        int idx = 0;
        int cyc = 0;
        bit done = 1'b0;
        bit rdy_prev = 1'b0;
        logic [7:0] cur = 8'h00;
        int bitpos = 0;
        int run = 0;
        bit pend_cnt = 1'b0;
        bit pend_busy = 1'b0;
        int idle_bad = 0;
        int ready_low = 0;
        int busy_after = -1;
        logic [7:0] obs_w [$];
        int obs_lp [$];
        int obs_run [$];
        int obs_cnt [$];
        logic [7:0] expv;

        valid[k] = 1'b0;
        while (!done && cyc < 40 * n + 60) begin
            @(negedge clk);
            cyc++;
            if (pend_cnt) begin
                obs_cnt.push_back(int'(cnt[k]));
                pend_cnt = 1'b0;
            end
            if (pend_busy) begin
                busy_after = int'(busy[k]);
                pend_busy = 1'b0;
            end
            if (!ready[k]) ready_low++;
            if (en[k]) begin
                if (bitpos == 0 && obs_w.size() > 0) obs_run.push_back(run);
                cur = {cur[6:0], d[k]};
                bitpos++;
                if (last[k]) begin
                    obs_w.push_back(cur);
                    obs_lp.push_back(bitpos);
                    bitpos = 0;
                    run = 0;
                    pend_cnt = 1'b1;
                    if (obs_w.size() == n) pend_busy = 1'b1;
                end
            end else begin
                run++;
                if (d[k] || last[k]) idle_bad++;
            end
            if (valid[k] && rdy_prev) idx++;
            rdy_prev = ready[k];
            if (idx >= n && !busy[k] && !pend_cnt && !pend_busy) begin
                done = 1'b1;
                valid[k] = 1'b0;
            end else if (idx < n) begin
                if (contig || $urandom_range(0, 3) != 0) begin
                    valid[k] = 1'b1;
                    data[k]  = words[idx];
                end else begin
                    valid[k] = 1'b0;
                    data[k]  = 8'($urandom);
                end
            end else begin
                valid[k] = 1'b0;
            end
        end
        valid[k] = 1'b0;

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: completed=%0d required=1 after %0d cycles", name, done, cyc);
        end
        checks++;
        if (obs_w.size() != n) begin
            errors++;
            $display("FAIL %s word_count: seen=%0d required=%0d", name, obs_w.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            logic [7:0] w;
            w = words[i];
            for (int b = 0; b < 8; b++) expv[7 - b] = lsb ? w[b] : w[7 - b];
            model_cnt[k] = (model_cnt[k] + 1) & cnt_mask[k];
            if (i < obs_w.size()) begin
                $display("%s: word %0d 0x%02h sent as 0x%02h (expect 0x%02h) cnt=%0d", name, i, w,
                         obs_w[i], expv, (i < obs_cnt.size()) ? obs_cnt[i] : -1);
                checks++;
                if (obs_w[i] !== expv) begin
                    errors++;
                    $display("FAIL %s bits[%0d]: seen=0x%02h required=0x%02h", name, i, obs_w[i], expv);
                end
                checks++;
                if (obs_lp[i] != 8) begin
                    errors++;
                    $display("FAIL %s last_pos[%0d]: seen=%0d required=8", name, i, obs_lp[i]);
                end
            end
            if (i < obs_cnt.size()) begin
                checks++;
                if (obs_cnt[i] != model_cnt[k]) begin
                    errors++;
                    $display("FAIL %s word_cnt[%0d]: seen=%0d required=%0d", name, i, obs_cnt[i], model_cnt[k]);
                end
            end
        end
        if (contig) begin
            checks++;
            if (obs_run.size() != n - 1) begin
                errors++;
                $display("FAIL %s gap_count: seen=%0d required=%0d", name, obs_run.size(), n - 1);
            end
            foreach (obs_run[i]) begin
                checks++;
                if (obs_run[i] != gap) begin
                    errors++;
                    $display("FAIL %s idle_run[%0d]: seen=%0d required=%0d", name, i, obs_run[i], gap);
                end
            end
            if (n > 1) begin
                checks++;
                if (ready_low == 0) begin
                    errors++;
                    $display("FAIL %s ready_low: seen=%0d cycles required>0", name, ready_low);
                end
            end
        end
        checks++;
        if (idle_bad != 0) begin
            errors++;
            $display("FAIL %s idle_data: seen=%0d bad cycles required=0", name, idle_bad);
        end
        checks++;
        if (busy_after != ((gap > 0) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s busy_after_last: seen=%0d required=%0d", name, busy_after, (gap > 0) ? 1 : 0);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({en[k], d[k], last[k], busy[k], ready[k]} !== 5'b00001 || cnt[k] !== 16'd0) begin
                errors++;
                $display("FAIL reset[%0d]: en,d,last,busy,ready=%b cnt=%0d required=00001 cnt=0", k,
                         {en[k], d[k], last[k], busy[k], ready[k]}, cnt[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        wq = {};
        wq.push_back(8'hA5);
        run_words(0, wq, 1'b0, 0, 1'b1, "single_a5");
    endtask

    task automatic test_back_to_back;
        wq = {};
        wq.push_back(8'hFF);
        wq.push_back(8'h00);
        run_words(0, wq, 1'b0, 0, 1'b1, "back_to_back");
    endtask

    task automatic test_gap;
        wq = {};
        wq.push_back(8'h5A);
        wq.push_back(8'hC3);
        run_words(2, wq, 1'b0, 3, 1'b1, "gap3");
    endtask

    task automatic test_lsb_first;
        wq = {};
        wq.push_back(8'h01);
        run_words(1, wq, 1'b1, 0, 1'b1, "lsb_first");
    endtask

    task automatic test_reset_mid_word;
        int seen = 0;
        int cyc = 0;
        int en_bad = 0;
        @(negedge clk);
        valid[0] = 1'b1;
        data[0]  = 8'hC3;
        @(negedge clk);
        data[0]  = 8'h99;
        while (seen < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (en[0]) seen++;
        end
        checks++;
        if (seen != 3 || ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid setup: bits=%0d ready=%b required bits=3 ready=0", seen, ready[0]);
        end
        valid[0] = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({en[0], d[0], last[0], busy[0], ready[0]} !== 5'b00001 || cnt[0] !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid async: en,d,last,busy,ready=%b cnt=%0d required=00001 cnt=0",
                     {en[0], d[0], last[0], busy[0], ready[0]}, cnt[0]);
        end
        $display("reset_mid: reset asserted after %0d bits of 0xc3 with 0x99 held", seen);
        for (int k = 0; k < 4; k++) model_cnt[k] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (en[0] || busy[0]) en_bad++;
        end
        checks++;
        if (en_bad != 0) begin
            errors++;
            $display("FAIL reset_mid residue: seen=%0d active cycles required=0", en_bad);
        end
        wq = {};
        wq.push_back(8'h3C);
        run_words(0, wq, 1'b0, 0, 1'b1, "reset_resume");
    endtask

    task automatic test_cnt_wrap;
        wq = {};
        for (int i = 0; i < 5; i++) wq.push_back(8'($urandom_range(0, 255)));
        run_words(3, wq, 1'b0, 0, 1'b1, "cnt_wrap");
    endtask

    task automatic test_random;
        wq = {};
        for (int i = 0; i < 10; i++) wq.push_back(8'($urandom_range(0, 255)));
        run_words(0, wq, 1'b0, 0, 1'b0, "rand_stall");
        wq = {};
        for (int i = 0; i < 6; i++) wq.push_back(8'($urandom_range(0, 255)));
        run_words(1, wq, 1'b1, 0, 1'b1, "rand_lsb");
        wq = {};
        for (int i = 0; i < 5; i++) wq.push_back(8'($urandom_range(0, 255)));
        run_words(2, wq, 1'b0, 3, 1'b1, "rand_gap");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        valid = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            data[k] = 8'h00;
            model_cnt[k] = 0;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_lsb_first();
        test_reset_mid_word();
        test_cnt_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_stream_tx.md
Name: bit_stream_tx

Overview:
Transmit side of the single-bit enable-qualified serial stream (`en` + `d`, one bit per `clk`) consumed by the serial-input datapath.
- Accepts parallel words over a valid/ready handshake.
- Serializes each word onto `o_en`/`o_d`, with `o_last` marking the final bit.
- Counts transmitted words.
- Used as the stimulus source in place of ad-hoc bit drivers, and as the on-chip loopback source.

Parameters:
- DATA_W, 8: word width in bits; legal range >= 2.
- LSB_FIRST, 0: 0 sends MSB first, 1 sends LSB first.
- GAP_CYC, 0: idle cycles (`o_en`=0) forced between consecutive words; 0 means back-to-back.
- CNT_W, 16: width of the transmitted-word counter.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  block can accept a word; equals NOT hold_valid.
- s_data  in  DATA_W  input word, sampled when s_valid && s_ready at a rising edge.
- o_en  out  1  serial bit valid, registered.
- o_d  out  1  serial data bit, registered; 0 whenever o_en=0.
- o_last  out  1  high with the final bit of each word, registered.
- o_busy  out  1  state != IDLE or hold_valid.
- o_word_cnt  out  CNT_W  number of words fully transmitted, modulo 2^CNT_W.

Behaviour:
Reset (asynchronous, takes effect immediately):
- o_en=0, o_d=0, o_last=0, o_word_cnt=0.
- hold_valid=0 (so s_ready=1 and o_busy=0), shift register=0, bit index=0, gap counter=0, state=IDLE.

Input buffering:
- One-word hold register plus a shift register.
- Accept at edge N only if s_ready=1. s_ready does not combinationally depend on the load, so accept and load never happen on the same edge.

States:
- IDLE:
  - o_en=0.
  - If hold_valid at an edge: load the shift register from hold, clear hold_valid, drive bit 0 of the word, go to SHIFT.
  - Latency: word accepted at edge N → first bit visible after edge N+1.
- SHIFT:
  - o_en=1 for exactly DATA_W consecutive cycles.
  - Bit order: s_data[DATA_W-1] down to [0] when LSB_FIRST=0; [0] up to [DATA_W-1] when LSB_FIRST=1.
  - o_last=1 only on bit DATA_W-1 of the sequence.
  - The edge that ends the last bit increments o_word_cnt (wraps at 2^CNT_W) and branches:
    - GAP_CYC=0 and hold_valid: load the next word and stay in SHIFT. No bubble; o_en stays 1.
    - GAP_CYC>0: go to GAP, counter=GAP_CYC.
    - Otherwise: go to IDLE, o_en=0.
- GAP:
  - o_en=0, o_d=0, o_last=0 for exactly GAP_CYC cycles.
  - Then: load the next word if hold_valid (→ SHIFT), else → IDLE.

Boundary conditions:
- Hold full while shifting: s_ready=0; s_data is ignored; the upstream source must hold its word.
- Hold freed on the load edge: s_ready=1 the following cycle. DATA_W >= 2 guarantees a sustained no-bubble rate with GAP_CYC=0.
- s_valid withdrawn without handshake: no effect.
- Reset mid-word: the partial word and the held word are discarded and not counted. Resumption starts cleanly on the next accepted word.
- Counter wrap: all ones +1 → 0, with no flag.

Decomposition:
- Package bit_stream_pkg holds:
  - state enum {IDLE, SHIFT, GAP};
  - default constants for DATA_W, GAP_CYC and CNT_W;
  - the clog2-based bit-index width helper.
- One natural sub-module, bit_stream_shreg: a loadable DATA_W shift register parameterized by LSB_FIRST, with load/shift controls and a bit output.
- The FSM, hold register, gap counter and word counter stay in bit_stream_tx.

Test Plan:
- DATA_W=8, LSB_FIRST=0, send 0xA5 → 8 consecutive o_en cycles, o_d = 1,0,1,0,0,1,0,1; o_last on the 8th only; o_word_cnt=1; o_busy drops the cycle after.
- Back-to-back 0xFF then 0x00 (GAP_CYC=0), s_valid held high → 16 contiguous o_en cycles (8 ones, then 8 zeros); o_last at cycles 8 and 16; s_ready=0 while hold is full; cnt=2.
- GAP_CYC=3, two words queued → exactly 3 cycles with o_en=0, o_d=0 between the words.
- LSB_FIRST=1, send 0x01 → o_d = 1 followed by seven 0s.
- Assert rst_n=0 after 3 bits of 0xC3 with a second word held → o_en=0 immediately and cnt=0; after release, s_ready=1, and a new 0x3C is transmitted intact with cnt=1.
- CNT_W=2, send 5 words → o_word_cnt sequence 1,2,3,0,1.
